// File: rtl/feature_loader.sv
// feature_loader: packs a valid/ready feature stream into a flat classifier input vector,
// waits a settle window, then holds the sampled class on a registered valid/ready result.
module feature_loader #(
  parameter int NUM_A    = 21,
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 2,
  parameter int SETTLE   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH_A-1:0]         s_data,
  input  logic                       s_last,
  output logic [NUM_A*WIDTH_A-1:0]   feat,
  input  logic [OUTWIDTH-1:0]        cls_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUTWIDTH-1:0]        m_class,
  output logic                       frame_err
);
  localparam int KW = $clog2(NUM_A);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_A - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);
  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_HOLD} state_t;
  state_t r_st, w_st_n;
  logic [KW-1:0] r_k;
  logic [SW-1:0] r_sc;
  logic [NUM_A*WIDTH_A-1:0] r_feat;
  logic r_mv, r_ferr;
  logic [OUTWIDTH-1:0] r_mc;
  logic w_acc, w_last_k, w_sdone;
  assign s_ready   = (r_st == ST_LOAD) && !rst;
  assign w_acc     = s_valid && s_ready;
  assign w_last_k  = (r_k == K_LAST);
  assign w_sdone   = (r_st == ST_SETTLE) && (r_sc == S_LAST);
  assign feat      = r_feat;
  assign m_valid   = r_mv;
  assign m_class   = r_mc;
  assign frame_err = r_ferr;
  always_comb begin
    w_st_n = (w_acc && s_last && w_last_k)         ? ST_SETTLE :
             w_sdone                               ? ST_HOLD   :
             (r_st == ST_HOLD && r_mv && m_ready)  ? ST_LOAD   : r_st;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= ST_LOAD;
    else     r_st <= w_st_n;
  end
  // a frame is well formed only when s_last coincides with the final slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_sc   <= '0;
      r_feat <= '0;
      r_mv   <= 1'b0;
      r_mc   <= '0;
      r_ferr <= 1'b0;
    end else begin
      r_ferr <= w_acc && (s_last != w_last_k);
      if (w_acc) r_k <= (s_last || w_last_k) ? '0 : r_k + 1'b1;
      for (int i = 0; i < NUM_A; i++)
        if (w_acc && r_k == i[KW-1:0]) r_feat[i*WIDTH_A +: WIDTH_A] <= s_data;
      r_sc <= (r_st == ST_SETTLE) ? r_sc + 1'b1 : '0;
      if (w_sdone) begin
        r_mv <= 1'b1;
        r_mc <= cls_in;
      end else if (r_st == ST_HOLD && m_ready) begin
        r_mv <= 1'b0;
      end
    end
  end
endmodule

// File: doc/feature_loader.md
# feature_loader

Upstream stage of the Cardio classifier. Accepts one WIDTH_A-bit feature per beat over a valid/ready stream and packs NUM_A features into the flat vector that drives the combinational classifier's `inp` port. After a configurable settle window, it samples the classifier's `out` port and presents the class on a registered valid/ready result interface.

## Interface
- NUM_A, 21, features per frame
- WIDTH_A, 4, bits per feature
- OUTWIDTH, 2, class width
- SETTLE, 2, cycles between frame completion and class sampling (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- s_valid  in  1  feature beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  WIDTH_A  feature value, unsigned
- s_last  in  1  marks final beat of a frame
- feat  out  NUM_A*WIDTH_A  packed vector to classifier `inp`
- cls_in  in  OUTWIDTH  classifier `out`
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_class  out  OUTWIDTH  registered class
- frame_err  out  1  one-cycle pulse on malformed frame

## Operation
- States: LOAD, SETTLE, HOLD. Reset state is LOAD.
- s_ready = (state==LOAD) && !rst. Handshakes while rst is high are ignored.
- A beat is accepted when s_valid && s_ready.
- Beat index k is the 0-based count of accepted beats. Beat k writes feat[(k+1)*WIDTH_A-1 : k*WIDTH_A].
- Index counter is $clog2(NUM_A) bits wide.
- LOAD, accepted beat with k<NUM_A-1 and !s_last: store, k←k+1.
- LOAD, accepted beat with k<NUM_A-1 and s_last: store, pulse frame_err, k←0, stay LOAD. The frame is discarded.
- LOAD, accepted beat with k==NUM_A-1 and s_last: store, k←0, go to SETTLE, settle counter←0.
- LOAD, accepted beat with k==NUM_A-1 and !s_last: store, pulse frame_err, k←0, stay LOAD. The frame is discarded.
- Discarded frames leave stale slot contents in feat. feat is never cleared except by reset.
- SETTLE: settle counter increments each cycle. On the cycle it equals SETTLE-1: m_class←cls_in, m_valid←1, go to HOLD.
- HOLD: m_valid=1 and m_class stable. On m_valid && m_ready: m_valid←0, go to LOAD.
- Beats offered in SETTLE or HOLD are not accepted.
- feat is written only in LOAD. It is therefore stable from the last beat until HOLD exits.
- frame_err and m_valid never assert in the same cycle.
- Out of scope: concurrent load and result hold (no overlap).

## Timing
- Reset values (applied immediately, asynchronously): state LOAD, k=0, settle counter 0, feat=0, m_class=0, m_valid=0, frame_err=0. s_ready=0 while rst is high and 1 on the first cycle after release.
- Latency: last beat accepted at edge n; m_valid and m_class update at edge n+SETTLE.
- s_ready drops from the cycle after edge n. It returns the cycle after the m_valid && m_ready edge.
- Minimum frame period is NUM_A + SETTLE + 1 cycles with continuous s_valid and m_ready=1.
- frame_err is high exactly one cycle, following the offending acceptance edge.
- Reset during SETTLE or HOLD aborts the frame: no m_valid and no frame_err.
- Reset mid-LOAD discards the partial frame without frame_err.
- Gaps in s_valid during LOAD stall the index. They have no other effect.

## Test plan
- Reset: assert rst mid-cycle → all outputs zero immediately. s_ready=0 during reset and 1 the cycle after release.
- Nominal frame (SETTLE=2): beats s_data=k%16 for k=0..20, s_last on k=20; stub cls_in=2'd2 → feat[3:0]=0, feat[63:60]=15, feat[83:80]=4. m_valid=1 and m_class=2 at edge n+2, m_ready=1 → m_valid=0 next cycle, s_ready=1.
- Backpressure and gaps: random s_valid gaps during load; m_ready low 5 cycles after m_valid → m_valid and m_class held. s_ready=0 throughout and extra offered beats are not accepted. Release → one result only.
- Early s_last on k=10 → frame_err pulses one cycle, no m_valid, k restarts. The following well-formed frame yields the correct class.
- Missing s_last on k=20 → frame_err pulse, no m_valid, s_ready stays 1.
- Reset asserted in SETTLE → m_valid never rises, m_class=0. The next frame after release is processed normally.
